// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and a
// multi-cycle mult/div occupancy FSM, plus a saturating stall-cycle counter.
module hazard_ctrl #(
   parameter int unsigned MD_CYCLES = 32,
   parameter int unsigned PERF_W    = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [4:0]        id_rs_i,
   input  logic [4:0]        id_rt_i,
   input  logic              id_uses_rt_i,
   input  logic [4:0]        ex_rt_i,
   input  logic              ex_mem_read_i,
   input  logic              branch_taken_i,
   input  logic              md_start_i,
   output logic              pc_keep_o,
   output logic              if_id_keep_o,
   output logic              if_id_clear_o,
   output logic              id_ex_keep_o,
   output logic              id_ex_clear_o,
   output logic              ex_mem_clear_o,
   output logic              md_done_o,
   output logic              busy_o,
   output logic [PERF_W-1:0] stall_cycles_o
);

   localparam int unsigned CNT_W = $clog2(MD_CYCLES);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] md_cnt;
   logic             load_use_c;

   assign load_use_c = ex_mem_read_i && (ex_rt_i != 5'd0) &&
                       ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

   assign busy_o = (state == BUSY);

   // Combinational pipeline controls; forced low while reset is asserted.
   always_comb begin
      pc_keep_o      = 1'b0;
      if_id_keep_o   = 1'b0;
      if_id_clear_o  = 1'b0;
      id_ex_keep_o   = 1'b0;
      id_ex_clear_o  = 1'b0;
      ex_mem_clear_o = 1'b0;
      md_done_o      = 1'b0;
      if (!rst_i) begin
         unique case (state)
            IDLE: begin
               if (md_start_i) begin
                  pc_keep_o      = 1'b1;
                  if_id_keep_o   = 1'b1;
                  id_ex_keep_o   = 1'b1;
                  ex_mem_clear_o = 1'b1;
               end else if (branch_taken_i) begin
                  if_id_clear_o  = 1'b1;
                  id_ex_clear_o  = 1'b1;
               end else if (load_use_c) begin
                  pc_keep_o      = 1'b1;
                  if_id_keep_o   = 1'b1;
                  id_ex_clear_o  = 1'b1;
               end
            end
            BUSY: begin
               if (md_cnt != '0) begin
                  pc_keep_o      = 1'b1;
                  if_id_keep_o   = 1'b1;
                  id_ex_keep_o   = 1'b1;
                  ex_mem_clear_o = 1'b1;
               end else begin
                  md_done_o      = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Occupancy FSM: the start cycle plus MD_CYCLES-1 busy stalls, then release.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state  <= IDLE;
         md_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (md_start_i) begin
                  state  <= BUSY;
                  md_cnt <= CNT_W'(MD_CYCLES - 1);
               end
            end
            BUSY: begin
               if (md_cnt != '0) begin
                  md_cnt <= md_cnt - CNT_W'(1);
               end else begin
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Saturating count of stalled PC cycles.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cycles_o <= '0;
      end else if (pc_keep_o && (stall_cycles_o != '1)) begin
         stall_cycles_o <= stall_cycles_o + PERF_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MD_CYCLES=4, PERF_W=4) with a
// cycle-level behavioural model for randomized traffic.
module tb_hazard_ctrl;

   localparam int unsigned MD = 4;
   localparam int unsigned PW = 4;
   localparam int          SAT = (1 << PW) - 1;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [4:0]    id_rs_i, id_rt_i, ex_rt_i;
   logic          id_uses_rt_i, ex_mem_read_i, branch_taken_i, md_start_i;
   logic          pc_keep_o, if_id_keep_o, if_id_clear_o, id_ex_keep_o;
   logic          id_ex_clear_o, ex_mem_clear_o, md_done_o, busy_o;
   logic [PW-1:0] stall_cycles_o;
   logic [7:0]    obs;

   int total = 0;
   int bad   = 0;

   // Model state: BUSY cycles still to come, and the expected perf count.
   int busy_left;
   int stall_cnt;

   logic [7:0] md_exp [5] = '{8'b1101_0100, 8'b1101_0101, 8'b1101_0101,
                              8'b1101_0101, 8'b0000_0011};

   hazard_ctrl #(.MD_CYCLES(MD), .PERF_W(PW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
      .ex_rt_i(ex_rt_i), .ex_mem_read_i(ex_mem_read_i),
      .branch_taken_i(branch_taken_i), .md_start_i(md_start_i),
      .pc_keep_o(pc_keep_o), .if_id_keep_o(if_id_keep_o),
      .if_id_clear_o(if_id_clear_o), .id_ex_keep_o(id_ex_keep_o),
      .id_ex_clear_o(id_ex_clear_o), .ex_mem_clear_o(ex_mem_clear_o),
      .md_done_o(md_done_o), .busy_o(busy_o), .stall_cycles_o(stall_cycles_o)
   );

   always #5 clk_i = ~clk_i;

   assign obs = {pc_keep_o, if_id_keep_o, if_id_clear_o, id_ex_keep_o,
                 id_ex_clear_o, ex_mem_clear_o, md_done_o, busy_o};

   task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic [4:0] exrt, input logic rd, input logic br,
                         input logic md);
      @(negedge clk_i);
      id_rs_i = rs; id_rt_i = rt; id_uses_rt_i = uses;
      ex_rt_i = exrt; ex_mem_read_i = rd; branch_taken_i = br; md_start_i = md;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      id_rs_i = '0; id_rt_i = '0; id_uses_rt_i = 1'b0; ex_rt_i = '0;
      ex_mem_read_i = 1'b0; branch_taken_i = 1'b0; md_start_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      busy_left = 0;
      stall_cnt = 0;
   endtask

   // Expected {pc_keep,if_id_keep,if_id_clear,id_ex_keep,id_ex_clear,ex_mem_clear,md_done,busy}.
   function automatic logic [7:0] predict();
      logic lu;
      lu = ex_mem_read_i && ex_rt_i != 0 &&
           (ex_rt_i == id_rs_i || (id_uses_rt_i && ex_rt_i == id_rt_i));
      if (busy_left > 1)       return 8'b1101_0101;
      else if (busy_left == 1) return 8'b0000_0011;
      else if (md_start_i)     return 8'b1101_0100;
      else if (branch_taken_i) return 8'b0010_1000;
      else if (lu)             return 8'b1100_1000;
      else                     return 8'b0000_0000;
   endfunction

   task automatic advance(input logic [7:0] e);
      if (e[7]) stall_cnt = (stall_cnt < SAT) ? stall_cnt + 1 : SAT;
      if (busy_left > 0)   busy_left = busy_left - 1;
      else if (md_start_i) busy_left = MD;
   endtask

   task automatic test_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      id_rs_i = 5'd2; id_rt_i = 5'd2; id_uses_rt_i = 1'b1; ex_rt_i = 5'd2;
      ex_mem_read_i = 1'b1; branch_taken_i = 1'b1; md_start_i = 1'b1;
      #1;
      total++;
      if (obs !== 8'h00) begin
         bad++; $display("FAIL reset_outputs got=%b want=%b", obs, 8'h00);
      end
      total++;
      if (stall_cycles_o !== '0) begin
         bad++; $display("FAIL reset_stall got=%0d want=0", stall_cycles_o);
      end
      do_reset();
   endtask

   task automatic test_load_use();
      do_reset();
      set_in(5'd2, 5'd4, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
      #1;
      total++;
      if (obs !== 8'b1100_1000) begin
         bad++; $display("FAIL load_use_stall got=%b want=%b", obs, 8'b1100_1000);
      end
      set_in(5'd2, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      total++;
      if (obs !== 8'h00 || stall_cycles_o !== PW'(1)) begin
         bad++; $display("FAIL load_use_after got=%b/%0d want=%b/1", obs, stall_cycles_o, 8'h00);
      end
   endtask

   task automatic test_no_stall();
      do_reset();
      set_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
      #1;
      total++;
      if (obs !== 8'h00) begin
         bad++; $display("FAIL lu_rt_zero got=%b want=%b", obs, 8'h00);
      end
      set_in(5'd1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
      #1;
      total++;
      if (obs !== 8'h00) begin
         bad++; $display("FAIL lu_rt_unused got=%b want=%b", obs, 8'h00);
      end
      set_in(5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
      #1;
      total++;
      if (obs !== 8'b1100_1000) begin
         bad++; $display("FAIL lu_rt_used got=%b want=%b", obs, 8'b1100_1000);
      end
   endtask

   task automatic test_branch();
      do_reset();
      set_in(5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
      #1;
      total++;
      if (obs !== 8'b0010_1000) begin
         bad++; $display("FAIL branch_wins got=%b want=%b", obs, 8'b0010_1000);
      end
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      total++;
      if (stall_cycles_o !== '0) begin
         bad++; $display("FAIL branch_stall_cnt got=%0d want=0", stall_cycles_o);
      end
   endtask

   // md_start_i held: two back-to-back operations with no idle gap.
   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
         #1;
         total++;
         if (obs !== md_exp[i % 5]) begin
            bad++; $display("FAIL md_seq cyc=%0d got=%b want=%b", i, obs, md_exp[i % 5]);
         end
      end
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      total++;
      if (obs !== 8'h00 || stall_cycles_o !== PW'(8)) begin
         bad++; $display("FAIL md_total got=%b/%0d want=%b/8", obs, stall_cycles_o, 8'h00);
      end
   endtask

   task automatic test_reset_busy();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
         #1;
         total++;
         if (obs !== md_exp[i]) begin
            bad++; $display("FAIL abort_pre cyc=%0d got=%b want=%b", i, obs, md_exp[i]);
         end
      end
      rst_i = 1'b1;
      #1;
      total++;
      if (obs !== 8'h00 || stall_cycles_o !== '0) begin
         bad++; $display("FAIL abort_now got=%b/%0d want=%b/0", obs, stall_cycles_o, 8'h00);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      md_start_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (obs !== 8'h00) begin
            bad++; $display("FAIL abort_no_done cyc=%0d got=%b want=%b", i, obs, 8'h00);
         end
         @(negedge clk_i);
      end
      for (int i = 0; i < 5; i++) begin
         set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
         #1;
         total++;
         if (obs !== md_exp[i]) begin
            bad++; $display("FAIL abort_restart cyc=%0d got=%b want=%b", i, obs, md_exp[i]);
         end
      end
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      total++;
      if (stall_cycles_o !== PW'(4)) begin
         bad++; $display("FAIL abort_restart_cnt got=%0d want=4", stall_cycles_o);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         set_in(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
      end
      set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      total++;
      if (stall_cycles_o !== PW'(SAT)) begin
         bad++; $display("FAIL saturate got=%0d want=%0d", stall_cycles_o, SAT);
      end
   endtask

   task automatic test_random();
      logic [7:0] e;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 7) == 0));
         #1;
         e = predict();
         total++;
         if (obs !== e || stall_cycles_o !== PW'(stall_cnt)) begin
            bad++;
            $display("FAIL random cyc=%0d got=%b/%0d want=%b/%0d", i, obs, stall_cycles_o, e, stall_cnt);
         end
         advance(e);
      end
   endtask

   initial begin
      rst_i = 1'b1;
      busy_left = 0;
      stall_cnt = 0;
      test_reset();
      test_load_use();
      test_no_stall();
      test_branch();
      test_back_to_back();
      test_reset_busy();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
